// File: rtl/tbs_pkg.sv
`default_nettype none
// =============================================================================
// Module      : tbs_pkg
// Description : Shared constants, FSM state types and packet byte builders for
//               the TBS event UART. TBS_EVENT_UART_PARITY_EN adds SER_PARITY.
// Revision    : 1.0 - initial release
// =============================================================================
package tbs_pkg;

    localparam int TS_BITWIDTH  = 13;
    localparam int PKT_SYNC_BIT = 7;
    // Bits of the timestamp carried below the sync bit of byte1.
    localparam int TS_LO_BITS   = PKT_SYNC_BIT;

    typedef enum logic [1:0] {
        PKT_IDLE  = 2'd0,
        PKT_LOAD0 = 2'd1,
        PKT_SEND0 = 2'd2,
        PKT_SEND1 = 2'd3
    } pkt_state_t;

`ifdef TBS_EVENT_UART_PARITY_EN
    typedef enum logic [2:0] {
        SER_IDLE   = 3'd0,
        SER_START  = 3'd1,
        SER_DATA   = 3'd2,
        SER_PARITY = 3'd3,
        SER_STOP   = 3'd4
    } ser_state_t;
`else
    typedef enum logic [2:0] {
        SER_IDLE   = 3'd0,
        SER_START  = 3'd1,
        SER_DATA   = 3'd2,
        SER_STOP   = 3'd4
    } ser_state_t;
`endif

    function automatic logic [7:0] pkt_byte0(
        input logic                              dir,
        input logic [TS_BITWIDTH-TS_LO_BITS-1:0] ts_hi
    );
        logic [7:0] w_b;
        w_b               = {1'b0, dir, ts_hi};
        w_b[PKT_SYNC_BIT] = 1'b1;
        return w_b;
    endfunction

    function automatic logic [7:0] pkt_byte1(input logic [TS_LO_BITS-1:0] ts_lo);
        logic [7:0] w_b;
        w_b               = {1'b0, ts_lo};
        w_b[PKT_SYNC_BIT] = 1'b0;
        return w_b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tbs_uart_tx.sv
`default_nettype none
// =============================================================================
// Module      : tbs_uart_tx
// Description : Byte serializer, 8N1 (8E1 with TBS_EVENT_UART_PARITY_EN).
//               A start_i during the last stop-bit cycle chains the next byte.
// Revision    : 1.0 - initial release
// =============================================================================
module tbs_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic [7:0] data_i,
    input  logic       start_i,
    output logic       tx_o,
    output logic       done_o,
    output logic       busy_o
);
    import tbs_pkg::*;

    localparam int              c_cnt_w    = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);

    ser_state_t         r_state, w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]         r_bit, w_bit_nxt;
    logic [7:0]         r_shift, w_shift_nxt;
    logic               r_tx, w_tx_nxt;
    logic               w_bit_end;
    logic               w_done;

    assign w_bit_end = (r_cnt == c_cnt_last);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_done      = 1'b0;
        case (r_state)
            SER_IDLE: begin
                if (start_i) begin
                    w_state_nxt = SER_START;
                    w_cnt_nxt   = '0;
                    w_shift_nxt = data_i;
                end
            end
            SER_START: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_bit_end) begin
                    w_state_nxt = SER_DATA;
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                end
            end
            SER_DATA: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    // Rotate rather than shift so the byte's parity survives.
                    w_shift_nxt = {r_shift[0], r_shift[7:1]};
                    w_bit_nxt   = r_bit + 1'b1;
                    if (r_bit == 3'd7) begin
`ifdef TBS_EVENT_UART_PARITY_EN
                        w_state_nxt = SER_PARITY;
`else
                        w_state_nxt = SER_STOP;
`endif
                    end
                end
            end
`ifdef TBS_EVENT_UART_PARITY_EN
            SER_PARITY: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_bit_end) begin
                    w_state_nxt = SER_STOP;
                    w_cnt_nxt   = '0;
                end
            end
`endif
            SER_STOP: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_bit_end) begin
                    w_done    = 1'b1;
                    w_cnt_nxt = '0;
                    if (start_i) begin
                        w_state_nxt = SER_START;
                        w_shift_nxt = data_i;
                    end else begin
                        w_state_nxt = SER_IDLE;
                    end
                end
            end
            default: w_state_nxt = SER_IDLE;
        endcase
    end

    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            SER_START:  w_tx_nxt = 1'b0;
            SER_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef TBS_EVENT_UART_PARITY_EN
            SER_PARITY: w_tx_nxt = ^w_shift_nxt;
`endif
            default:    w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state <= SER_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    assign tx_o   = r_tx;
    assign done_o = w_done;
    assign busy_o = (r_state != SER_IDLE);

endmodule
`default_nettype wire

// File: rtl/tbs_event_uart.sv
`default_nettype none
// =============================================================================
// Module      : tbs_event_uart
// Description : Timestamps TBS crossing events, queues them and streams each as
//               a 2-byte UART packet. TBS_EVENT_UART_PARITY_EN selects 8E1.
// Revision    : 1.0 - initial release
// =============================================================================
module tbs_event_uart #(
    parameter int CLK_FREQ   = 8000000,
    parameter int BAUD_RATE  = 500000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic                          enable_i,
    input  logic                          tick_i,
    input  logic                          event_valid_i,
    input  logic                          event_dir_i,
    output logic                          uart_tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          overflow_o
);
    import tbs_pkg::*;

    localparam int c_clks_per_bit = CLK_FREQ / BAUD_RATE;
    localparam int c_aw           = $clog2(FIFO_DEPTH);
    localparam int c_ew           = TS_BITWIDTH + 1;
    localparam logic [TS_BITWIDTH-1:0] c_ts_max = '1;

    logic [TS_BITWIDTH-1:0] r_ts;
    logic [c_ew-1:0]        r_mem [FIFO_DEPTH];
    logic [c_aw:0]          r_wr_ptr, r_rd_ptr, r_level;
    logic                   r_overflow;
    logic [TS_LO_BITS-1:0]  r_ts_lo;
    pkt_state_t             r_pkt_state, w_pkt_state_nxt;

    logic            w_empty, w_full, w_push_req, w_push, w_drop, w_pop;
    logic [c_ew-1:0] w_head;
    logic            w_ser_start, w_ser_done, w_ser_busy, w_ser_tx;
    logic [7:0]      w_ser_data;

    always_ff @(posedge clock_i) begin
        if (reset_i || !enable_i) begin
            r_ts <= '0;
        end else if (event_valid_i) begin
            r_ts <= tick_i ? TS_BITWIDTH'(1) : '0;
        end else if (tick_i && (r_ts != c_ts_max)) begin
            r_ts <= r_ts + 1'b1;
        end
    end

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                        (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign w_push_req = enable_i && event_valid_i;
    assign w_push     = w_push_req && !w_full;
    assign w_drop     = w_push_req && w_full;
    assign w_pop      = (r_pkt_state == PKT_LOAD0);
    assign w_head     = r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clock_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= {event_dir_i, r_ts};
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else if (!enable_i) begin
            // Flush; an entry popped this cycle is already latched in r_ts_lo.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_pkt_state <= PKT_IDLE;
            r_ts_lo     <= '0;
        end else begin
            r_pkt_state <= w_pkt_state_nxt;
            if (w_pop) r_ts_lo <= w_head[TS_LO_BITS-1:0];
        end
    end

    // Byte1 is requested in the serializer's last stop cycle so the bytes abut.
    always_comb begin
        w_pkt_state_nxt = r_pkt_state;
        w_ser_start     = 1'b0;
        w_ser_data      = pkt_byte1(r_ts_lo);
        case (r_pkt_state)
            PKT_IDLE: begin
                if (!w_empty && enable_i) w_pkt_state_nxt = PKT_LOAD0;
            end
            PKT_LOAD0: begin
                w_ser_start     = 1'b1;
                w_ser_data      = pkt_byte0(w_head[c_ew-1], w_head[TS_BITWIDTH-1:TS_LO_BITS]);
                w_pkt_state_nxt = PKT_SEND0;
            end
            PKT_SEND0: begin
                if (w_ser_done) begin
                    w_ser_start     = 1'b1;
                    w_pkt_state_nxt = PKT_SEND1;
                end
            end
            PKT_SEND1: begin
                if (w_ser_done) w_pkt_state_nxt = PKT_IDLE;
            end
            default: w_pkt_state_nxt = PKT_IDLE;
        endcase
    end

    tbs_uart_tx #(
        .CLKS_PER_BIT(c_clks_per_bit)
    ) u_uart_tx (
        .clock_i(clock_i),
        .reset_i(reset_i),
        .data_i (w_ser_data),
        .start_i(w_ser_start),
        .tx_o   (w_ser_tx),
        .done_o (w_ser_done),
        .busy_o (w_ser_busy)
    );

    assign uart_tx_o    = w_ser_tx;
    assign busy_o       = (r_pkt_state != PKT_IDLE) || w_ser_busy;
    assign fifo_level_o = r_level;
    assign overflow_o   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_tbs_event_uart.sv
`default_nettype none
// =============================================================================
// Module      : tb_tbs_event_uart
// Description : Directed stimulus for tbs_event_uart with a UART-decoding
//               scoreboard monitor. TBS_EVENT_UART_PARITY_EN selects 8E1 frames.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_tbs_event_uart;

    localparam int c_cpb = 16;
`ifdef TBS_EVENT_UART_PARITY_EN
    localparam int c_nbits = 11;
`else
    localparam int c_nbits = 10;
`endif

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       enable   = 1'b0;
    logic       tick     = 1'b0;
    logic       ev_valid = 1'b0;
    logic       ev_dir   = 1'b0;
    logic       uart_tx;
    logic       busy;
    logic [3:0] level;
    logic       overflow;

    int         n_tests    = 0;
    int         n_fail     = 0;
    int         cyc        = 0;
    int         rx_count   = 0;
    bit         mon_ignore = 1'b0;
    logic [7:0] exp_q[$];

    tbs_event_uart dut (
        .clock_i      (clk),
        .reset_i      (rst),
        .enable_i     (enable),
        .tick_i       (tick),
        .event_valid_i(ev_valid),
        .event_dir_i  (ev_dir),
        .uart_tx_o    (uart_tx),
        .busy_o       (busy),
        .fifo_level_o (level),
        .overflow_o   (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    task automatic wait_start(output int at);
        for (int k = 0; k < 2000; k++) begin
            if (uart_tx === 1'b0) break;
            step();
        end
        at = cyc;
        check("start_seen", uart_tx, 0);
    endtask

    task automatic wait_drain(input int max);
        for (int k = 0; k < max; k++) begin
            if (exp_q.size() == 0 && busy == 1'b0) break;
            step();
        end
        check("drain_queue", exp_q.size(), 0);
        check("drain_busy", busy, 0);
    endtask

    // Scoreboard monitor: decodes every frame on the line and checks it in order.
    initial begin : monitor
        logic [10:0] fr;
        logic [7:0]  b;
        bit          glitch;
        bit          ok;
        forever begin
            @(negedge clk);
            if (uart_tx === 1'b0) begin
                fr     = '0;
                glitch = 1'b0;
                for (int bi = 0; bi < c_nbits; bi++) begin
                    for (int k = 0; k < c_cpb; k++) begin
                        if (bi != 0 || k != 0) @(negedge clk);
                        if (k == 0) fr[bi] = uart_tx;
                        else if (uart_tx !== fr[bi]) glitch = 1'b1;
                    end
                end
                b  = fr[8:1];
                ok = !glitch && (fr[0] == 1'b0) && (fr[c_nbits-1] == 1'b1);
`ifdef TBS_EVENT_UART_PARITY_EN
                ok = ok && (fr[9] == ^b);
`endif
                if (!mon_ignore) begin
                    check("rx_frame", ok, 1);
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL rx_unexpected: got byte %0h, expected no frame", b);
                    end else begin
                        check("rx_byte", b, exp_q.pop_front());
                    end
                end
                rx_count++;
            end
        end
    end

    initial begin : stim
        int ev_cyc;
        int st;
        int rc0;
        bit bad;

        // Reset and idle
        repeat (3) step();
        check("reset_tx", uart_tx, 1);
        check("reset_busy", busy, 0);
        check("reset_level", level, 0);
        check("reset_overflow", overflow, 0);
        rst    = 1'b0;
        enable = 1'b1;
        bad    = 1'b0;
        repeat (1000) begin
            step();
            if (uart_tx !== 1'b1 || busy !== 1'b0 || level !== 4'd0) bad = 1'b1;
        end
        check("idle_1000", bad, 0);

        // ts = 300, upward crossing
        ticks(300);
        exp_q.push_back(8'hC2);
        exp_q.push_back(8'h2C);
        ev_cyc   = cyc;
        ev_valid = 1'b1;
        ev_dir   = 1'b1;
        step();
        ev_valid = 1'b0;
        check("level_after_push", level, 1);
        wait_start(st);
        check("start_latency", st - ev_cyc, 3);
        for (int k = 0; k < 1000; k++) begin
            if (!busy) break;
            step();
        end
        check("packet_length", cyc - st, 2 * c_nbits * c_cpb);
        wait_drain(200);

        // Saturated timestamp, downward crossing
        ticks(10000);
        exp_q.push_back(8'hBF);
        exp_q.push_back(8'h7F);
        ev_valid = 1'b1;
        ev_dir   = 1'b0;
        step();
        ev_valid = 1'b0;
        wait_drain(1000);

        // Ten back-to-back events: first popped, eight queued, last dropped
        for (int i = 0; i < 10; i++) begin
            if (i < 9) begin
                exp_q.push_back(i[0] ? 8'hC0 : 8'h80);
                exp_q.push_back(8'h00);
            end
            ev_valid = 1'b1;
            ev_dir   = i[0];
            step();
        end
        ev_valid = 1'b0;
        check("burst_level", level, 8);
        check("burst_overflow", overflow, 1);
        wait_drain(4000);
        check("overflow_sticky", overflow, 1);
        check("burst_level_end", level, 0);

        // Disable midway through byte0 with three entries queued
        ticks(5);
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'h05);
        for (int i = 0; i < 4; i++) begin
            ev_valid = 1'b1;
            ev_dir   = (i == 0);
            step();
        end
        ev_valid = 1'b0;
        check("queued_level", level, 3);
        wait_start(st);
        repeat (80) step();
        enable = 1'b0;
        step();
        check("flush_level", level, 0);
        tick = 1'b1;
        for (int k = 0; k < 300; k++) begin
            ev_valid = (k % 50 == 0);
            ev_dir   = 1'b1;
            step();
        end
        ev_valid = 1'b0;
        tick     = 1'b0;
        wait_drain(800);
        bad = 1'b0;
        repeat (200) begin
            step();
            if (uart_tx !== 1'b1 || level !== 4'd0) bad = 1'b1;
        end
        check("no_more_packets", bad, 0);

        // Re-enable: counter was held at 0; reset during byte1
        enable   = 1'b1;
        ev_valid = 1'b1;
        ev_dir   = 1'b0;
        exp_q.push_back(8'h80);
        rc0 = rx_count;
        step();
        ev_valid = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            if (rx_count > rc0) break;
            step();
        end
        check("byte0_received", rx_count - rc0, 1);
        mon_ignore = 1'b1;
        repeat (50) step();
        check("tx_mid_byte1", uart_tx, 0);
        rst = 1'b1;
        step();
        check("abort_tx", uart_tx, 1);
        check("abort_busy", busy, 0);
        check("abort_level", level, 0);
        check("abort_overflow", overflow, 0);
        rst = 1'b0;
        repeat (c_nbits * c_cpb + 20) step();
        mon_ignore = 1'b0;
        check("abort_queue", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
